// File: rtl/ili_bus_pkg.sv
// Shared types and constants for the ILI9341 8080-style bus controller.
// ILI_BUS_READ_EN adds the RD_LO/RD_HI states used by the data read path.
package ili_bus_pkg;

   localparam int AV_ADDR_W = 2;
   localparam int AV_DATA_W = 32;
   localparam int LCD_DAT_W = 16;
   localparam int CNT_W     = 8;

   localparam logic [AV_ADDR_W-1:0] ADDR_CMD    = 2'd0;
   localparam logic [AV_ADDR_W-1:0] ADDR_DATA   = 2'd1;
   localparam logic [AV_ADDR_W-1:0] ADDR_STATUS = 2'd2;

   localparam int DEF_WR_LOW_CYC  = 2;
   localparam int DEF_WR_HIGH_CYC = 2;
   localparam int DEF_RD_LOW_CYC  = 18;
   localparam int DEF_RD_HIGH_CYC = 5;

`ifdef ILI_BUS_READ_EN
   typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI} state_t;
`else
   typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;
`endif

   // Counter is loaded with length-1 so the done flag rises on the last cycle of a phase.
   function automatic logic [CNT_W-1:0] phase_len(input int cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/ili_bus_if.sv
// Avalon-MM slave handshake bundle between a bus master and ili_bus_ctrl.
// Master drives the request; slave returns readdata/waitrequest combinationally.
interface ili_bus_if;
   import ili_bus_pkg::*;

   logic [AV_ADDR_W-1:0] address;
   logic                 chipselect;
   logic                 write_n;
   logic                 read_n;
   logic [AV_DATA_W-1:0] writedata;
   logic [AV_DATA_W-1:0] readdata;
   logic                 waitrequest;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata, waitrequest
   );

endinterface

// File: rtl/ili_bus_phase_cnt.sv
// Loadable down-counter timing one strobe phase; done is high while the count is zero.
// Load takes effect on the next edge; it saturates at zero and never wraps.
module ili_bus_phase_cnt
   import ili_bus_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/ili_bus_ctrl.sv
// Avalon-MM to ILI9341 16-bit 8080 bus bridge; writes post in one cycle, data reads stall until RD_HI ends.
// ILI_BUS_READ_EN enables the panel read path; without it addr 1 reads return 0 and lcd_rd_n stays high.
module ili_bus_ctrl
   import ili_bus_pkg::*;
#(
   parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
   parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
   parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
   parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ili_bus_if.slave             avs,
   output logic                 lcd_cs_n,
   output logic                 lcd_rs,
   output logic                 lcd_wr_n,
   output logic                 lcd_rd_n,
   output logic [LCD_DAT_W-1:0] lcd_data_o,
   output logic                 lcd_data_oe,
   input  logic [LCD_DAT_W-1:0] lcd_data_i
);

   state_t               state_d, state_q;
   logic                 lcd_cs_n_d, lcd_cs_n_q;
   logic                 lcd_rs_d, lcd_rs_q;
   logic                 lcd_wr_n_d, lcd_wr_n_q;
   logic                 lcd_data_oe_d, lcd_data_oe_q;
   logic [LCD_DAT_W-1:0] lcd_data_o_d, lcd_data_o_q;

   logic                 phase_load;
   logic [CNT_W-1:0]     phase_val;
   logic                 phase_done;

   logic                 wr_bus;
   logic                 busy;

   // Only addr 0/1 writes reach the panel; addr 2/3 writes complete without effect.
   assign wr_bus = avs.chipselect & ~avs.write_n & ~avs.address[1];
   assign busy   = (state_q != IDLE);

`ifdef ILI_BUS_READ_EN
   logic                 lcd_rd_n_d, lcd_rd_n_q;
   logic [LCD_DAT_W-1:0] rd_cap_d, rd_cap_q;
   logic                 rd_done_d, rd_done_q;
   logic                 rd_data_req;

   assign rd_data_req = avs.chipselect & ~avs.read_n & avs.write_n
                      & (avs.address == ADDR_DATA);
`else
   logic unused_rd_path;
   assign unused_rd_path = ^{lcd_data_i, avs.read_n}
                         ^ (RD_LOW_CYC > 0) ^ (RD_HIGH_CYC > 0);
`endif

   logic unused_wdata;
   assign unused_wdata = ^avs.writedata[AV_DATA_W-1:LCD_DAT_W];

   ili_bus_phase_cnt u_phase_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (phase_load),
      .load_val (phase_val),
      .done     (phase_done)
   );

   always_comb begin
      state_d      = state_q;
      phase_load   = 1'b0;
      phase_val    = '0;
      lcd_rs_d     = lcd_rs_q;
      lcd_data_o_d = lcd_data_o_q;
`ifdef ILI_BUS_READ_EN
      rd_cap_d     = rd_cap_q;
      rd_done_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (wr_bus) begin
               state_d      = WR_LO;
               phase_load   = 1'b1;
               phase_val    = phase_len(WR_LOW_CYC);
               lcd_rs_d     = (avs.address == ADDR_DATA);
               lcd_data_o_d = avs.writedata[LCD_DAT_W-1:0];
            end
`ifdef ILI_BUS_READ_EN
            // rd_done_q marks the completion cycle of the previous read, not a new request.
            else if (rd_data_req && !rd_done_q) begin
               state_d    = RD_LO;
               phase_load = 1'b1;
               phase_val  = phase_len(RD_LOW_CYC);
               lcd_rs_d   = 1'b1;
            end
`endif
         end
         WR_LO: begin
            if (phase_done) begin
               state_d    = WR_HI;
               phase_load = 1'b1;
               phase_val  = phase_len(WR_HIGH_CYC);
            end
         end
         WR_HI: begin
            if (phase_done) begin
               state_d = IDLE;
            end
         end
`ifdef ILI_BUS_READ_EN
         RD_LO: begin
            if (phase_done) begin
               state_d    = RD_HI;
               phase_load = 1'b1;
               phase_val  = phase_len(RD_HIGH_CYC);
               rd_cap_d   = lcd_data_i;
            end
         end
         RD_HI: begin
            if (phase_done) begin
               state_d   = IDLE;
               rd_done_d = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // Strobes decode the next state so the pins line up with state_q after the edge.
      lcd_cs_n_d    = (state_d == IDLE);
      lcd_wr_n_d    = (state_d != WR_LO);
      lcd_data_oe_d = (state_d == WR_LO) || (state_d == WR_HI);
`ifdef ILI_BUS_READ_EN
      lcd_rd_n_d    = (state_d != RD_LO);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         lcd_cs_n_q    <= 1'b1;
         lcd_rs_q      <= 1'b0;
         lcd_wr_n_q    <= 1'b1;
         lcd_data_oe_q <= 1'b0;
         lcd_data_o_q  <= '0;
`ifdef ILI_BUS_READ_EN
         lcd_rd_n_q    <= 1'b1;
         rd_cap_q      <= '0;
         rd_done_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         lcd_cs_n_q    <= lcd_cs_n_d;
         lcd_rs_q      <= lcd_rs_d;
         lcd_wr_n_q    <= lcd_wr_n_d;
         lcd_data_oe_q <= lcd_data_oe_d;
         lcd_data_o_q  <= lcd_data_o_d;
`ifdef ILI_BUS_READ_EN
         lcd_rd_n_q    <= lcd_rd_n_d;
         rd_cap_q      <= rd_cap_d;
         rd_done_q     <= rd_done_d;
`endif
      end
   end

   always_comb begin
      avs.waitrequest = 1'b0;
      if (reset_n) begin
         if (wr_bus) begin
            avs.waitrequest = busy;
         end
`ifdef ILI_BUS_READ_EN
         else if (rd_data_req) begin
            avs.waitrequest = !((state_q == IDLE) && rd_done_q);
         end
`endif
      end
   end

   always_comb begin
      avs.readdata = '0;
      case (avs.address)
         ADDR_STATUS: avs.readdata = {{(AV_DATA_W-1){1'b0}}, busy};
         ADDR_DATA: begin
`ifdef ILI_BUS_READ_EN
            avs.readdata = {{(AV_DATA_W-LCD_DAT_W){1'b0}}, rd_cap_q};
`endif
         end
         default: avs.readdata = '0;
      endcase
   end

   assign lcd_cs_n    = lcd_cs_n_q;
   assign lcd_rs      = lcd_rs_q;
   assign lcd_wr_n    = lcd_wr_n_q;
   assign lcd_data_o  = lcd_data_o_q;
   assign lcd_data_oe = lcd_data_oe_q;
`ifdef ILI_BUS_READ_EN
   assign lcd_rd_n    = lcd_rd_n_q;
`else
   assign lcd_rd_n    = 1'b1;
`endif

endmodule

// File: tb/tb_ili_bus_ctrl.sv
// Scoreboard bench for ili_bus_ctrl: stimulus pushes expected panel writes, strobe lengths and read data;
// a negedge monitor pops and compares whenever the DUT shows a completed transfer.
module tb_ili_bus_ctrl;
   import ili_bus_pkg::*;

   localparam int WL = 2;
   localparam int WH = 2;
   localparam int RL = 18;
   localparam int RH = 5;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
   logic [15:0] lcd_data_o;
   logic [15:0] lcd_data_i = 16'h0000;

   always #5 clk = ~clk;

   ili_bus_if avs();

   ili_bus_ctrl #(
      .WR_LOW_CYC  (WL),
      .WR_HIGH_CYC (WH),
      .RD_LOW_CYC  (RL),
      .RD_HIGH_CYC (RH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .avs         (avs),
      .lcd_cs_n    (lcd_cs_n),
      .lcd_rs      (lcd_rs),
      .lcd_wr_n    (lcd_wr_n),
      .lcd_rd_n    (lcd_rd_n),
      .lcd_data_o  (lcd_data_o),
      .lcd_data_oe (lcd_data_oe),
      .lcd_data_i  (lcd_data_i)
   );

   typedef struct packed {
      logic        rs;
      logic [15:0] dat;
   } lcd_wr_t;

   lcd_wr_t     exp_wr[$];
   logic [31:0] exp_rd[$];
   int          exp_cs[$];
   int          exp_rdlo[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic missing(input string name, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT produced 0x%0h with nothing expected", name, act);
   endtask

   // Monitor: run lengths of active-low strobes, panel write contents, Avalon read completions.
   int wr_lo_cnt = 0;
   int cs_cnt    = 0;
   int rd_lo_cnt = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         wr_lo_cnt = 0;
         cs_cnt    = 0;
         rd_lo_cnt = 0;
      end else begin
         check("strobe_exclusion", {(lcd_wr_n | lcd_rd_n), ~(lcd_data_oe & ~lcd_rd_n)}, 2'b11);

         if (!lcd_wr_n) begin
            wr_lo_cnt++;
         end else if (wr_lo_cnt > 0) begin
            if (exp_wr.size() == 0) begin
               missing("unexpected_lcd_write", {15'd0, lcd_rs, lcd_data_o});
            end else begin
               lcd_wr_t e;
               e = exp_wr.pop_front();
               check("lcd_write_rs_data_oe", {lcd_rs, lcd_data_o, lcd_data_oe}, {e.rs, e.dat, 1'b1});
               check("wr_n_low_cycles", wr_lo_cnt, WL);
            end
            wr_lo_cnt = 0;
         end

         if (!lcd_cs_n) begin
            cs_cnt++;
         end else if (cs_cnt > 0) begin
            if (exp_cs.size() == 0) missing("unexpected_cs_run", cs_cnt);
            else check("cs_n_low_cycles", cs_cnt, exp_cs.pop_front());
            cs_cnt = 0;
         end

         if (!lcd_rd_n) begin
            rd_lo_cnt++;
         end else if (rd_lo_cnt > 0) begin
            if (exp_rdlo.size() == 0) missing("unexpected_rd_strobe", rd_lo_cnt);
            else check("rd_n_low_cycles", rd_lo_cnt, exp_rdlo.pop_front());
            rd_lo_cnt = 0;
         end

         if (avs.chipselect && !avs.read_n && avs.write_n && !avs.waitrequest) begin
            if (exp_rd.size() == 0) missing("unexpected_read", avs.readdata);
            else check("readdata", avs.readdata, exp_rd.pop_front());
         end
      end
   end

   // Tasks start just after a rising edge and return just after the edge that accepted the transfer.
   task automatic av_write(input logic [1:0] a, input logic [15:0] d, input logic also_rd,
                           output int waits);
      if (a[1] == 1'b0) begin
         exp_wr.push_back({(a == 2'd1), d});
         exp_cs.push_back(WL + WH);
      end
      avs.address    = a;
      avs.writedata  = {16'hDEAD, d};
      avs.chipselect = 1'b1;
      avs.write_n    = 1'b0;
      avs.read_n     = ~also_rd;
      waits = 0;
      @(negedge clk);
      while (avs.waitrequest && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (avs.waitrequest) missing("write_wait_timeout", waits);
      @(posedge clk);
      #2;
      avs.chipselect = 1'b0;
      avs.write_n    = 1'b1;
      avs.read_n     = 1'b1;
   endtask

   task automatic av_read(input logic [1:0] a, input logic [31:0] exp, output int waits);
      exp_rd.push_back(exp);
      avs.address    = a;
      avs.chipselect = 1'b1;
      avs.read_n     = 1'b0;
      avs.write_n    = 1'b1;
      waits = 0;
      @(negedge clk);
      while (avs.waitrequest && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (avs.waitrequest) missing("read_wait_timeout", waits);
      @(posedge clk);
      #2;
      avs.chipselect = 1'b0;
      avs.read_n     = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      // A pending addr 1 read during reset must not stall the master.
      avs.address    = 2'd1;
      avs.chipselect = 1'b1;
      avs.read_n     = 1'b0;
      avs.write_n    = 1'b1;
      avs.writedata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe, lcd_data_o, avs.waitrequest},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
      @(posedge clk);
      #2;
      reset_n        = 1'b1;
      avs.chipselect = 1'b0;
      avs.read_n     = 1'b1;
      idle_cycles(2);

      av_read(2'd2, 32'h0000_0000, w);
      check("status_idle_waits", w, 0);
      av_read(2'd3, 32'h0000_0000, w);
      check("addr3_read_waits", w, 0);

      // Command write, then status polled while the write is in WR_LO.
      av_write(2'd0, 16'h002C, 1'b0, w);
      check("cmd_write_waits", w, 0);
      av_read(2'd2, 32'h0000_0001, w);
      check("status_busy_waits", w, 0);
      idle_cycles(6);

      av_write(2'd1, 16'hF800, 1'b0, w);
      check("b2b_first_waits", w, 0);
      av_write(2'd1, 16'h07E0, 1'b0, w);
      check("b2b_second_waits", w, WL + WH);
      idle_cycles(8);

      av_write(2'd2, 16'h1234, 1'b0, w);
      check("addr2_write_waits", w, 0);
      av_write(2'd3, 16'h5678, 1'b0, w);
      check("addr3_write_waits", w, 0);
      idle_cycles(3);
      av_read(2'd2, 32'h0000_0000, w);
      @(negedge clk);
      check("hold_after_ignored_writes", {lcd_rs, lcd_data_o, lcd_cs_n}, {1'b1, 16'h07E0, 1'b1});
      @(posedge clk);
      #2;

      av_write(2'd1, 16'h00AA, 1'b1, w);
      check("rw_collision_waits", w, 0);
      idle_cycles(8);

`ifdef ILI_BUS_READ_EN
      lcd_data_i = 16'h9341;
      exp_cs.push_back(RL + RH);
      exp_rdlo.push_back(RL);
      av_read(2'd1, 32'h0000_9341, w);
      check("data_read_waits", w, 1 + RL + RH);
      lcd_data_i = 16'h0000;
      @(negedge clk);
      check("hold_after_read", {lcd_rs, lcd_data_o}, {1'b1, 16'h00AA});
      @(posedge clk);
      #2;
`else
      lcd_data_i = 16'h9341;
      av_read(2'd1, 32'h0000_0000, w);
      check("data_read_disabled_waits", w, 0);
      @(negedge clk);
      check("rd_n_tied_high", lcd_rd_n, 1'b1);
      @(posedge clk);
      #2;
`endif
      idle_cycles(2);

      // Reset lands during the first WR_LO cycle; the aborted write is dropped from the scoreboard.
      av_write(2'd0, 16'h0036, 1'b0, w);
      check("pre_abort_write_waits", w, 0);
      reset_n = 1'b0;
      exp_wr.delete();
      exp_cs.delete();
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs", {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_data_oe, lcd_rs, lcd_data_o},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      av_read(2'd2, 32'h0000_0000, w);
      check("status_after_abort_waits", w, 0);

      av_write(2'd1, 16'h1234, 1'b0, w);
      check("post_reset_write_waits", w, 0);
      idle_cycles(8);

      check("scoreboard_drained", exp_wr.size() + exp_rd.size() + exp_cs.size() + exp_rdlo.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ili_bus_ctrl.md
ILI_BUS_CTRL -- requirements
Module: ili_bus_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WR_LOW_CYC   2   clk cycles lcd_wr_n held low per write (min 1)
  WR_HIGH_CYC  2   clk cycles lcd_wr_n held high after write (min 1)
  RD_LOW_CYC   18  clk cycles lcd_rd_n held low per read (min 1)
  RD_HIGH_CYC  5   clk cycles lcd_rd_n held high after read (min 1)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk          in   1   single system clock, all logic on rising edge
  reset_n      in   1   synchronous, active-low reset
  address      in   2   Avalon-MM word address
  chipselect   in   1   slave select
  write_n      in   1   write strobe, active low
  read_n       in   1   read strobe, active low
  writedata    in   32  write data; bits [15:0] used
  readdata     out  32  read data
  waitrequest  out  1   stall Avalon master
  lcd_cs_n     out  1   ILI9341 chip select, active low
  lcd_rs       out  1   ILI9341 D/C: 0 command, 1 data
  lcd_wr_n     out  1   ILI9341 write strobe
  lcd_rd_n     out  1   ILI9341 read strobe
  lcd_data_o   out  16  bus output data
  lcd_data_oe  out  1   bus output enable (tristate control at top level)
  lcd_data_i   in   16  bus input data
REQ-003 Clock is clk; reset is reset_n, synchronous, active low.

Function
REQ-004 Register map SHALL be: addr 0 write = command (rs=0); addr 1 write = data (rs=1); addr 1 read = bus data read (rs=1); addr 2 read = status, bit0 busy, bits[31:1] 0; addr 3 read = 0; writes to addr 2/3 ignored.
REQ-005 FSM states SHALL be IDLE, WR_LO, WR_HI, RD_LO, RD_HI with a single down-counter for phase length.
REQ-006 Write in IDLE SHALL be accepted with waitrequest=0 in the same cycle; data/rs latched; next state WR_LO.
REQ-007 Write while not IDLE SHALL see waitrequest=1 until the cycle after FSM returns to IDLE, then be accepted per REQ-006.
REQ-008 WR_LO: lcd_cs_n=0, lcd_wr_n=0, lcd_data_oe=1 for exactly WR_LOW_CYC cycles; WR_HI: lcd_cs_n=0, lcd_wr_n=1, data/oe held, for exactly WR_HIGH_CYC cycles; then IDLE.
REQ-009 Data read (addr 1) SHALL hold waitrequest=1 from first request cycle through RD_HI; FSM IDLE->RD_LO->RD_HI->IDLE; readdata={16'b0,captured} valid in the single cycle waitrequest drops.
REQ-010 RD_LO: lcd_cs_n=0, lcd_rd_n=0, lcd_data_oe=0 for RD_LOW_CYC cycles; lcd_data_i sampled on last RD_LO cycle; RD_HI: lcd_rd_n=1, cs held low, RD_HIGH_CYC cycles.
REQ-011 Status/addr 3 reads SHALL complete with waitrequest=0, readdata combinational, any state.
REQ-012 In IDLE: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_data_oe=0; lcd_rs and lcd_data_o hold last value.
REQ-013 lcd_wr_n and lcd_rd_n SHALL never be low simultaneously; lcd_data_oe=1 never while lcd_rd_n=0.
REQ-014 Simultaneous read_n and write_n asserted SHALL be treated as write; read ignored.
REQ-015 All lcd_* outputs SHALL be registered (no glitches).

Reset
REQ-016 reset_n=0 at any clock edge SHALL force IDLE, aborting any transaction mid-phase: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data_o=0, lcd_data_oe=0, captured read data=0, waitrequest=0.

Configuration
REQ-017 Macro ILI_BUS_READ_EN defined: read path per REQ-009/010. Undefined: RD_LO/RD_HI absent, lcd_rd_n tied 1, addr 1 read returns 0 with waitrequest=0, lcd_data_i unused.

Structure
REQ-018 Package ili_bus_pkg SHALL hold FSM state enum, register address constants (ADDR_CMD=0, ADDR_DATA=1, ADDR_STATUS=2), default timing constants.
REQ-019 Sub-module ili_bus_phase_cnt (loadable down-counter, done flag) is natural; otherwise flat.

Verification
REQ-020 Write 0x2C to addr 0 from IDLE -> waitrequest=0; lcd_rs=0, lcd_data_o=0x002C, lcd_wr_n low exactly 2 cycles, high 2, cs_n low 4 cycles total.
REQ-021 Back-to-back writes 0xF800, 0x07E0 to addr 1 -> second write waitrequest=1 for 4 cycles, then two bus writes with rs=1, values in order.
REQ-022 Read addr 1 with lcd_data_i=0x9341 -> waitrequest=1 for 23+ cycles, lcd_rd_n low 18 cycles, readdata=0x00009341 on release.
REQ-023 Read addr 2 during write -> 0x00000001, waitrequest=0; in IDLE -> 0x00000000.
REQ-024 reset_n=0 in WR_LO cycle 1 -> next edge all strobes high, cs_n=1, oe=0, status=0.
REQ-025 ILI_BUS_READ_EN undefined: read addr 1 -> 0x00000000, waitrequest=0, lcd_rd_n constant 1.
